// File: rtl/mskand_hpc1_sched.sv
// ============================================================================
// Module   : mskand_hpc1_sched
// Purpose  : Operand/randomness scheduler and result FIFO for an HPC1 masked AND gadget.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module mskand_hpc1_sched #(
  parameter int d      = `DEFAULTSHARES,
  parameter int FIFO_D = 8,
  parameter int REF_N_RND = (d == 2) ? 1 : (d == 3) ? 2 : (d == 4) ? 4 : (d == 5) ? 5 :
                            (d == 6) ? 7 : (d == 7) ? 9 : (d == 8) ? 11 : d * (d - 1) / 2,
  parameter int DOM_RND   = d * (d - 1) / 2,
  parameter int HPC1RND   = REF_N_RND + DOM_RND
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [d-1:0]       i_in_a,
  input  logic [d-1:0]       i_in_b,
  input  logic               i_rnd_valid,
  output logic               o_rnd_ready,
  input  logic [HPC1RND-1:0] i_rnd_in,
  output logic [d-1:0]       o_g_ina,
  output logic [d-1:0]       o_g_inb,
  output logic [HPC1RND-1:0] o_g_rnd,
  input  logic [d-1:0]       i_g_out,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [d-1:0]       o_out_data,
  output logic               o_busy
);

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = PW + 1;
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(FIFO_D);

  logic                 r_v1, r_v2, r_v3, r_v4;
  logic [REF_N_RND-1:0] r_ref1;
  logic [DOM_RND-1:0]   r_dom1, r_dom2, r_dom3;
  logic [d-1:0]         r_a1, r_a2, r_a3;
  logic [d-1:0]         r_b1, r_b2;

  logic [d-1:0]         r_mem [FIFO_D];
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;

  logic [2:0]           w_inflight;
  logic [CW:0]          w_used;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  // Credit covers every result that will eventually land in the FIFO, so a
  // same-cycle pop only frees space from the next cycle on.
  assign w_inflight = 3'(r_v1) + 3'(r_v2) + 3'(r_v3) + 3'(r_v4);
  assign w_used     = {1'b0, r_count} + (CW + 1)'(w_inflight);
  assign w_accept   = rst_n & i_in_valid & i_rnd_valid & (w_used < C_DEPTH);
  assign w_push     = r_v4;
  assign w_pop      = (r_count != '0) & i_out_ready;

  assign o_in_ready  = w_accept;
  assign o_rnd_ready = w_accept;

  // Stage data is zeroed whenever its slot is empty, so idle gadget ports carry no shares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_v4   <= 1'b0;
      r_ref1 <= '0;
      r_dom1 <= '0;
      r_dom2 <= '0;
      r_dom3 <= '0;
      r_a1   <= '0;
      r_a2   <= '0;
      r_a3   <= '0;
      r_b1   <= '0;
      r_b2   <= '0;
    end else begin
      r_v1   <= w_accept;
      r_ref1 <= w_accept ? i_rnd_in[REF_N_RND-1:0] : '0;
      r_dom1 <= w_accept ? i_rnd_in[HPC1RND-1:REF_N_RND] : '0;
      r_a1   <= w_accept ? i_in_a : '0;
      r_b1   <= w_accept ? i_in_b : '0;
      r_v2   <= r_v1;
      r_dom2 <= r_dom1;
      r_a2   <= r_a1;
      r_b2   <= r_b1;
      r_v3   <= r_v2;
      r_dom3 <= r_dom2;
      r_a3   <= r_a2;
      r_v4   <= r_v3;
    end
  end

  assign o_g_rnd = {r_dom3, r_ref1};
  assign o_g_inb = r_b2;
  assign o_g_ina = r_a3;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_g_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_out_valid = (r_count != '0);
  assign o_out_data  = r_mem[r_rptr];
  assign o_busy      = r_v1 | r_v2 | r_v3 | r_v4 | (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_mskand_hpc1_sched.sv
// ============================================================================
// Module   : tb_mskand_hpc1_sched
// Purpose  : Randomized self-checking bench for mskand_hpc1_sched with a simple gadget model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mskand_hpc1_sched;

  localparam int D     = 2;
  localparam int FD    = 8;
  localparam int RW    = 2;
  localparam int NCYC  = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, rnd_valid, rnd_ready;
  logic [D-1:0]  in_a, in_b;
  logic [RW-1:0] rnd_in;
  logic [D-1:0]  g_ina, g_inb, g_out;
  logic [RW-1:0] g_rnd;
  logic          out_valid, out_ready, busy;
  logic [D-1:0]  out_data;

  always #5 clk = ~clk;

  mskand_hpc1_sched #(.d(D), .FIFO_D(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_a     (in_a),
    .i_in_b     (in_b),
    .i_rnd_valid(rnd_valid),
    .o_rnd_ready(rnd_ready),
    .i_rnd_in   (rnd_in),
    .o_g_ina    (g_ina),
    .o_g_inb    (g_inb),
    .o_g_rnd    (g_rnd),
    .i_g_out    (g_out),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_busy     (busy)
  );

  // Gadget stand-in: inb registered one cycle, combined with ina, result one cycle later.
  logic [D-1:0] gb_q, gout_q;
  always @(posedge clk) begin
    gb_q   <= g_inb;
    gout_q <= {g_rnd[1], ((^g_ina) & (^gb_q)) ^ g_rnd[1]};
  end
  assign g_out = gout_q;

  typedef struct {
    logic val;
    int   rdy;
  } res_t;

  res_t          q[$];
  logic [D-1:0]  e_a   [NCYC];
  logic [D-1:0]  e_b   [NCYC];
  logic          e_ref [NCYC];
  logic          e_dom [NCYC];
  int            cyc;
  int            outstanding;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCYC; i++) begin
      e_a[i] = '0; e_b[i] = '0; e_ref[i] = 1'b0; e_dom[i] = 1'b0;
    end
    q.delete();
    outstanding = 0;
  endtask

  task automatic step(input bit rst, input bit iv, input bit rv, input logic [D-1:0] a,
                      input logic [D-1:0] b, input logic [RW-1:0] r, input bit ordy);
    bit er, ev;
    @(negedge clk);
    rst_n = rst; in_valid = iv; rnd_valid = rv; in_a = a; in_b = b; rnd_in = r; out_ready = ordy;
    if (!rst) model_clear();
    #1;
    er = rst && iv && rv && (outstanding < FD);
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("in_ready",  32'(in_ready),  32'(er));
    chk("rnd_ready", 32'(rnd_ready), 32'(er));
    chk("g_ina",     32'(g_ina),     32'(e_a[cyc]));
    chk("g_inb",     32'(g_inb),     32'(e_b[cyc]));
    chk("g_rnd",     32'(g_rnd),     32'({e_dom[cyc], e_ref[cyc]}));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("busy",      32'(busy),      32'(outstanding != 0));
    if (ev) chk("out_value", 32'(^out_data), 32'(q[0].val));
    @(posedge clk);
    if (rst) begin
      if (ev && ordy) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (er) begin
        e_ref[cyc + 1] = r[0];
        e_b[cyc + 2]   = b;
        e_a[cyc + 3]   = a;
        e_dom[cyc + 3] = r[1];
        q.push_back('{val: (^a) & (^b), rdy: cyc + 5});
        outstanding++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, '0, ordy);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; in_a = '0; in_b = '0; rnd_in = '0;
    out_ready = 1'b0;
    model_clear();

    // Reset with requests pending: nothing may be accepted.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 1'b1);

    // Single operation, result 1 expected in A+5.
    step(1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 1'b1);
    idle(8, 1'b1);

    // Streaming.
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'b1, D'($urandom), D'($urandom), RW'($urandom), 1'b1);
    idle(8, 1'b1);

    // Backpressure: credit runs out at FIFO_D, resumes after pops begin.
    for (int i = 0; i < 14; i++)
      step(1'b1, 1'b1, 1'b1, D'($urandom), D'($urandom), RW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b1, D'($urandom), D'($urandom), RW'($urandom), 1'b1);
    idle(10, 1'b1);

    // Randomness starvation.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 2'b11, 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b11, 1'b1);
    idle(8, 1'b1);

    // Reset in A+2 of an operation.
    step(1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(10, 1'b1);

    // Freshness: counter-valued randomness, random output stalls.
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b1, D'($urandom), D'($urandom), RW'(i), 1'($urandom));
    idle(12, 1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 200; i++)
      step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
           D'($urandom), D'($urandom), RW'($urandom), ($urandom_range(0, 2) != 0));
    idle(20, 1'b1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
